// File: rtl/clock_reset_sequencer.sv
// Staggered per-channel reset release with per-channel divided clock-enable pulses.
// One shared sequence counter drives the ASSERT -> RELEASE -> RUN progression.
module clock_reset_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned STAGGER_CYCLES = 2,
  parameter int unsigned DIV_W          = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sw_rst_req,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  output logic [NUM_CH-1:0]       rst_n,
  output logic [NUM_CH-1:0]       clk_en,
  output logic                    seq_busy,
  output logic                    seq_done
);

  localparam int unsigned LAST_EDGE = HOLD_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES;
  localparam int unsigned CNT_W     = $clog2(LAST_EDGE + 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] seq_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             restart;

  // Hardware reset and a software request both restart the sequence at this edge.
  assign restart = reset | sw_rst_req;
  assign cnt_nxt = seq_cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (restart) begin
      state    <= ASSERT;
      seq_cnt  <= '0;
      rst_n    <= '0;
      seq_busy <= 1'b1;
      seq_done <= 1'b0;
    end else begin
      seq_done <= 1'b0;
      case (state)
        ASSERT, RELEASE: begin
          seq_cnt <= cnt_nxt;
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cnt_nxt == CNT_W'(HOLD_CYCLES + k * STAGGER_CYCLES)) rst_n[k] <= 1'b1;
          end
          if (cnt_nxt == CNT_W'(LAST_EDGE)) begin
            state    <= RUN;
            seq_busy <= 1'b0;
            seq_done <= 1'b1;
          end else if (cnt_nxt == CNT_W'(HOLD_CYCLES)) begin
            state <= RELEASE;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel divider: counts only once its channel was already out of reset.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_div
    logic [DIV_W-1:0] ratio;
    logic [DIV_W-1:0] limit;
    logic [DIV_W-1:0] cnt;
    logic             en;

    assign ratio     = div_ratio[k*DIV_W +: DIV_W];
    // A ratio of 0 behaves as 1; >= compare absorbs a ratio shrinking mid-count.
    assign limit     = (ratio == '0) ? '0 : ratio - DIV_W'(1);
    assign clk_en[k] = en;

    always_ff @(posedge clock) begin
      if (restart || !rst_n[k]) begin
        cnt <= '0;
        en  <= 1'b0;
      end else if (cnt >= limit) begin
        cnt <= '0;
        en  <= 1'b1;
      end else begin
        cnt <= cnt + DIV_W'(1);
        en  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// Directed bench for clock_reset_sequencer at default parameters.
// Expected values come from hand-derived edge formulas (release at 4+2k, done at 10).
module tb_clock_reset_sequencer;

  logic        clock;
  logic        reset;
  logic        sw_rst_req;
  logic [31:0] div_ratio;
  logic [3:0]  rst_n;
  logic [3:0]  clk_en;
  logic        seq_busy;
  logic        seq_done;

  int n_total = 0;
  int n_pass  = 0;

  clock_reset_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .sw_rst_req (sw_rst_req),
    .div_ratio  (div_ratio),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .seq_busy   (seq_busy),
    .seq_done   (seq_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] exp_rst(input int e);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (e >= 4 + 2 * k);
    return r;
  endfunction

  // Sequencer outputs at edge e counted from the sequence start edge.
  task automatic check_seq(input string tag, input int e);
    chk($sformatf("%s_rst_e%0d", tag, e), 32'(rst_n), 32'(exp_rst(e)));
    chk($sformatf("%s_busy_e%0d", tag, e), 32'(seq_busy), 32'(e < 10));
    chk($sformatf("%s_done_e%0d", tag, e), 32'(seq_done), 32'(e == 10));
  endtask

  // Ratios ch0=3, ch1=1, ch2=0, ch3=5; releases at 4,6,8,10.
  task automatic check_en(input string tag, input int e);
    logic [3:0] x;
    x[0] = (e >= 7) && ((e - 7) % 3 == 0);
    x[1] = (e >= 7);
    x[2] = (e >= 9);
    x[3] = (e >= 15) && ((e - 15) % 5 == 0);
    chk($sformatf("%s_en_e%0d", tag, e), 32'(clk_en), 32'(x));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rst"}, 32'(rst_n), 32'h0);
    chk({tag, "_en"}, 32'(clk_en), 32'h0);
    chk({tag, "_busy"}, 32'(seq_busy), 32'h1);
    chk({tag, "_done"}, 32'(seq_done), 32'h0);
  endtask

  task automatic restart_by_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    sw_rst_req = 1'b0;
    div_ratio  = {8'd5, 8'd0, 8'd1, 8'd3};

    // Power-up: reset high for three edges, the last one is edge 0.
    repeat (3) step();
    reset = 1'b0;
    check_cleared("por");
    for (int e = 1; e <= 22; e++) begin
      step();
      check_seq("por", e);
      check_en("por", e);
    end

    // Software request from RUN restarts the whole sequence.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    check_cleared("swrun");
    for (int e = 1; e <= 12; e++) begin
      step();
      check_seq("swrun", e);
      check_en("swrun", e);
    end

    // Software request at edge 7, mid-release.
    restart_by_reset();
    for (int e = 1; e <= 6; e++) step();
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    check_cleared("swmid");
    for (int e = 8; e <= 17; e++) begin
      step();
      check_seq("swmid", e - 7);
    end

    // Hardware reset at edge 7 for one cycle.
    restart_by_reset();
    for (int e = 1; e <= 6; e++) step();
    restart_by_reset();
    check_cleared("rstmid");
    for (int r = 1; r <= 10; r++) begin
      step();
      check_seq("rstmid", r);
    end

    // Held software request freezes the sequence at edge 0.
    sw_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_cleared($sformatf("swhold%0d", i));
    end
    sw_rst_req = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      check_seq("swhold", e);
    end

    // ch0 ratio 8 shortened to 2 once cnt_0 reaches 5 (after edge 9).
    div_ratio = {8'd8, 8'd8, 8'd8, 8'd8};
    restart_by_reset();
    for (int e = 1; e <= 9; e++) begin
      step();
      chk($sformatf("ratio8_en0_e%0d", e), 32'(clk_en[0]), 32'h0);
    end
    div_ratio[7:0] = 8'd2;
    for (int e = 10; e <= 16; e++) begin
      step();
      chk($sformatf("ratio2_en0_e%0d", e), 32'(clk_en[0]), 32'(e % 2 == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clock_reset_sequencer.md
CLOCK_RESET_SEQUENCER -- requirements
Module: clock_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of reset/clock-enable channels (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, cycles all channel resets stay asserted after sequence start (>=1).
REQ-003 SHALL have parameter STAGGER_CYCLES, default 2, cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter DIV_W, default 8, width of each per-channel divide ratio.
REQ-005 SHALL have port clock  input  1  single block clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port sw_rst_req  input  1  software re-sequence request, sampled every edge.
REQ-008 SHALL have port div_ratio  input  NUM_CH*DIV_W  per-channel clock-enable divide ratio, channel k in bits [k*DIV_W +: DIV_W].
REQ-009 SHALL have port rst_n  output  NUM_CH  per-channel active-low reset (APB PRESETn style).
REQ-010 SHALL have port clk_en  output  NUM_CH  per-channel registered clock-enable pulse.
REQ-011 SHALL have port seq_busy  output  1  high while any rst_n bit is low.
REQ-012 SHALL have port seq_done  output  1  one-cycle pulse when the last channel is released.

Function
REQ-013 SHALL implement FSM states ASSERT, RELEASE, RUN with one shared sequence counter, width sized for HOLD_CYCLES+(NUM_CH-1)*STAGGER_CYCLES.
REQ-014 Sequence start edge = edge 0: the last edge with reset high, or an edge sampling sw_rst_req=1.
REQ-015 ASSERT: all rst_n=0, counter counts edges; at edge HOLD_CYCLES rst_n[0] goes 1 and FSM enters RELEASE (enters RUN directly if NUM_CH=1).
REQ-016 RELEASE: rst_n[k] goes 1 at edge HOLD_CYCLES+k*STAGGER_CYCLES; released channels stay released; channel order is strictly 0 upward.
REQ-017 At the edge rst_n[NUM_CH-1] goes 1: FSM enters RUN, seq_busy goes 0, seq_done high for exactly that one cycle.
REQ-018 sw_rst_req=1 sampled in any state: all rst_n and clk_en 0, counter 0, FSM to ASSERT, seq_busy 1, seq_done 0; the sequence restarts with that edge as edge 0.
REQ-019 sw_rst_req held high: sequence held at edge 0 (no release) until it drops.
REQ-020 Per channel k: divider counter cnt_k (DIV_W bits) held at 0 and clk_en[k]=0 while rst_n[k]=0.
REQ-021 Per channel k, at each edge with rst_n[k] already 1: if cnt_k >= eff_ratio-1 then cnt_k<=0, clk_en[k]<=1; else cnt_k<=cnt_k+1, clk_en[k]<=0.
REQ-022 eff_ratio = div_ratio_k, except div_ratio_k=0 treated as 1; ratio 1 gives clk_en[k] continuously high from release edge+1.
REQ-023 First clk_en[k] pulse SHALL occur at edge (release edge + eff_ratio); pulse period = eff_ratio cycles.
REQ-024 div_ratio change mid-count SHALL take effect immediately via the >= compare (no counter overflow, no missed wrap beyond one period).
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 While reset=1: FSM=ASSERT, counter 0, rst_n all 0, clk_en all 0, cnt_k all 0, seq_busy 1, seq_done 0.
REQ-027 reset SHALL override sw_rst_req and any in-progress sequence on the same edge, including mid-RELEASE.
REQ-028 First edge with reset=0 is edge 1 of the sequence.

Verification
REQ-029 Defaults, reset high 3 cycles then low -> rst_n[0..3] rise at edges 4,6,8,10; seq_done single pulse at edge 10; seq_busy falls at edge 10.
REQ-030 div_ratio ch0=3, ch1=1, ch2=0 -> clk_en[0] high at edges 7,10,13,...; clk_en[1] high every edge from 7; clk_en[2] high every edge from 9.
REQ-031 In RUN, sw_rst_req pulsed at edge E -> all rst_n/clk_en 0 at E; rst_n[0] at E+4, rst_n[3] and seq_done at E+10.
REQ-032 sw_rst_req at edge 7 (mid-RELEASE, ch0-1 released) -> rst_n all 0 at 7; no seq_done at 10; rst_n[3] rises at 17.
REQ-033 reset asserted at edge 7 for 1 cycle -> all outputs to reset values at 7; sequence restarts, rst_n[0] 4 edges after reset falls.
REQ-034 ch0 ratio 8 changed to 2 at cnt_0=5 -> clk_en[0] pulses next edge, then every 2 cycles.
